// File: rtl/blake2_pkg.sv
// Shared definitions for the blake2 core and its message framer.
// Block geometry and framer state encoding.
package blake2_pkg;

  localparam int BLK_CLOG2 = 6;
  localparam int BLK_BYTES = 2 ** BLK_CLOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_PAD,
    S_WAIT_LO,
    S_WAIT_HI
  } framer_state_t;

endpackage

// File: rtl/blake2_msg_framer_if.sv
// Host byte-stream handshake into the blake2 message framer.
// The host is the master; the framer is the slave.
interface blake2_msg_framer_if;

  logic       in_v_i;
  logic [7:0] in_data_i;
  logic       in_last_i;
  logic       in_empty_i;
  logic       in_ready_o;

  modport master (
    output in_v_i,
    output in_data_i,
    output in_last_i,
    output in_empty_i,
    input  in_ready_o
  );

  modport slave (
    input  in_v_i,
    input  in_data_i,
    input  in_last_i,
    input  in_empty_i,
    output in_ready_o
  );

endinterface

// File: rtl/blake2_msg_framer.sv
// Frames a host byte stream into 64-byte blake2 core blocks,
// zero-padding the final block and tracking message length.
module blake2_msg_framer
  import blake2_pkg::*;
#(
  parameter int BB       = 128,
  parameter int BB_CLOG2 = BLK_CLOG2
) (
  input  logic                clk,
  input  logic                reset,
  blake2_msg_framer_if.slave  host,
  input  logic                core_ready_i,
  output logic                data_v_o,
  output logic [BB_CLOG2-1:0] data_idx_o,
  output logic [7:0]          data_o,
  output logic                block_first_o,
  output logic                block_last_o,
  output logic [BB-1:0]       ll_o,
  output logic                err_o
);

  localparam logic [BB_CLOG2-1:0] IDX_MAX = '1;

  framer_state_t       state, state_d;
  logic [BB_CLOG2-1:0] idx, idx_d;
  logic [BB-1:0]       ll_d;
  logic                first, first_d;
  logic                last_pend, last_pend_d;
  logic                err_d;
  logic                issue, issue_last;
  logic [7:0]          issue_data;
  logic                acc;

  assign host.in_ready_o = core_ready_i &
    (state == S_IDLE || state == S_STREAM);
  assign acc = host.in_v_i & host.in_ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      ll_o      <= '0;
      first     <= 1'b0;
      last_pend <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      ll_o      <= ll_d;
      first     <= first_d;
      last_pend <= last_pend_d;
      err_o     <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    ll_d        = ll_o;
    first_d     = first;
    last_pend_d = last_pend;
    err_d       = err_o;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_data  = '0;
    unique case (state)
      S_IDLE, S_STREAM: begin
        if (acc) begin
          if (state == S_IDLE) begin
            ll_d    = '0;
            first_d = 1'b1;
            err_d   = 1'b0;
            state_d = S_STREAM;
          end
          if (!host.in_empty_i) begin
            issue      = 1'b1;
            issue_data = host.in_data_i;
            issue_last = host.in_last_i;
            ll_d       = ll_d + 1'b1;
            idx_d      = idx + 1'b1;
            if (idx == IDX_MAX) begin
              state_d     = S_WAIT_LO;
              last_pend_d = host.in_last_i;
            end else if (host.in_last_i) begin
              state_d = S_PAD;
            end
          end else if (host.in_last_i) begin
            // previous block already went out non-last; nothing to pad
            if (idx == '0 && !first_d) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        issue      = 1'b1;
        issue_last = 1'b1;
        idx_d      = idx + 1'b1;
        if (idx == IDX_MAX) begin
          state_d     = S_WAIT_LO;
          last_pend_d = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!core_ready_i) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (core_ready_i) begin
          if (last_pend) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_STREAM;
            idx_d   = '0;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      data_o        <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      data_v_o     <= issue;
      block_last_o <= issue & issue_last;
      if (issue) begin
        data_idx_o    <= idx;
        data_o        <= issue_data;
        block_first_o <= first_d;
      end
    end
  end

endmodule
